agu: RTL and testbench

//  Address-generation stage directly upstream of the LSU. Accepts load/store ops from dispatch, forms

---
 rtl/agu_pkg.sv | 31 +++
 rtl/agu_align.sv | 41 ++++
 rtl/agu.sv | 182 ++++++++++++++++++
 tb/tb_agu.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agu_pkg.sv
// Shared AGU definitions; also holds the project width defines (defines.v content) and size encodings.
// Optional build macro: AGU_MISALIGN_EXCP_EN (misaligned ops raise an exception instead of issuing).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif
`ifndef ITAG_WIDTH
`define ITAG_WIDTH 4
`endif
`ifndef AGU_SIZE_B
`define AGU_SIZE_B 2'b00
`endif
`ifndef AGU_SIZE_H
`define AGU_SIZE_H 2'b01
`endif
`ifndef AGU_SIZE_W
`define AGU_SIZE_W 2'b10
`endif

package agu_pkg;
    localparam int unsigned XLEN    = `XLEN;
    localparam int unsigned DTCM_AW = `DTCM_ADDR_WIDTH;
    localparam int unsigned ITAG_W  = `ITAG_WIDTH;
    localparam int unsigned MASK_W  = XLEN / 8;

    localparam logic [1:0] SIZE_B = `AGU_SIZE_B;
    localparam logic [1:0] SIZE_H = `AGU_SIZE_H;
    localparam logic [1:0] SIZE_W = `AGU_SIZE_W;
endpackage

// File: rtl/agu_align.sv
// Combinational lane builder: misalignment detect, forced-aligned low address bits,
// store byte mask and lane-replicated store data.
module agu_align
    import agu_pkg::*;
(
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic [XLEN-1:0]   rs2_i,
    output logic              misalign_o,
    output logic [1:0]        addr_lo_o,
    output logic [MASK_W-1:0] wmask_o,
    output logic [XLEN-1:0]   wdata_o
);
    always_comb begin
        misalign_o = 1'b0;
        addr_lo_o  = addr_lo_i;
        wmask_o    = '1;
        wdata_o    = rs2_i;
        case (size_i)
            SIZE_B: begin
                wmask_o = MASK_W'(1) << addr_lo_i;
                wdata_o = {MASK_W{rs2_i[7:0]}};
            end
            SIZE_H: begin
                // Misaligned halves keep their half-lane; only addr[0] is dropped.
                misalign_o = addr_lo_i[0];
                addr_lo_o  = {addr_lo_i[1], 1'b0};
                wmask_o    = MASK_W'(3) << {addr_lo_i[1], 1'b0};
                wdata_o    = {(MASK_W / 2){rs2_i[15:0]}};
            end
            SIZE_W: begin
                misalign_o = |addr_lo_i;
                addr_lo_o  = 2'b00;
            end
            default: begin
                misalign_o = 1'b1;
                addr_lo_o  = 2'b00;
            end
        endcase
    end
endmodule

// File: rtl/agu.sv
// Address-generation stage: forms rs1+imm, registers one LSU command and counts outstanding commands.
// Build option AGU_MISALIGN_EXCP_EN diverts misaligned ops into an exception register.
module agu
    import agu_pkg::*;
#(
    parameter int unsigned OUTS_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              agu_i_valid,
    output logic              agu_i_ready,
    input  logic              agu_i_read,
    input  logic [XLEN-1:0]   agu_i_rs1,
    input  logic [XLEN-1:0]   agu_i_rs2,
    input  logic [XLEN-1:0]   agu_i_imm,
    input  logic [1:0]        agu_i_size,
    input  logic              agu_i_usign,
    input  logic [ITAG_W-1:0] agu_i_itag,
    output logic              agu_cmd_valid,
    input  logic              agu_cmd_ready,
    output logic              agu_cmd_read,
    output logic [DTCM_AW-1:0] agu_cmd_addr,
    output logic [XLEN-1:0]   agu_cmd_wdata,
    output logic [MASK_W-1:0] agu_cmd_wmask,
    output logic [ITAG_W-1:0] agu_cmd_itag,
    output logic              agu_cmd_usign,
    output logic [1:0]        agu_cmd_size,
    input  logic              agu_rsp_valid,
    output logic              agu_rsp_ready,
    output logic              agu_excp_valid,
    input  logic              agu_excp_ready,
    output logic [XLEN-1:0]   agu_excp_addr,
    output logic [ITAG_W-1:0] agu_excp_itag
);
    localparam int unsigned OUTS_CNT_W = $clog2(OUTS_DEPTH + 1);

    logic [XLEN-1:0]       sum;
    logic                  misalign;
    logic [1:0]            addr_lo;
    logic [MASK_W-1:0]     lane_mask;
    logic [XLEN-1:0]       lane_data;
    logic                  accept, issue, cmd_hs, rsp_take, excp_valid;
    logic [OUTS_CNT_W:0]   occupancy;

    logic                  cmd_valid_q, cmd_valid_d;
    logic                  cmd_read_q, cmd_usign_q;
    logic [DTCM_AW-1:0]    cmd_addr_q;
    logic [XLEN-1:0]       cmd_wdata_q;
    logic [MASK_W-1:0]     cmd_wmask_q;
    logic [ITAG_W-1:0]     cmd_itag_q;
    logic [1:0]            cmd_size_q;
    logic [OUTS_CNT_W-1:0] cnt_q, cnt_d;

    assign sum = agu_i_rs1 + agu_i_imm;

    agu_align u_align (
        .addr_lo_i  (sum[1:0]),
        .size_i     (agu_i_size),
        .rs2_i      (agu_i_rs2),
        .misalign_o (misalign),
        .addr_lo_o  (addr_lo),
        .wmask_o    (lane_mask),
        .wdata_o    (lane_data)
    );

    // A pending command that has not yet handshaken still counts toward the limit.
    assign occupancy   = (OUTS_CNT_W + 1)'(cnt_q) + (OUTS_CNT_W + 1)'(cmd_valid_q);
    assign agu_i_ready = (~cmd_valid_q | agu_cmd_ready)
                       & (occupancy < (OUTS_CNT_W + 1)'(OUTS_DEPTH))
                       & (~excp_valid | agu_excp_ready);
    assign accept      = agu_i_valid & agu_i_ready;
    assign cmd_hs      = cmd_valid_q & agu_cmd_ready;
    assign rsp_take    = agu_rsp_valid & (cnt_q != '0);

`ifdef AGU_MISALIGN_EXCP_EN
    logic              excp_valid_q, excp_valid_d;
    logic [XLEN-1:0]   excp_addr_q;
    logic [ITAG_W-1:0] excp_itag_q;

    assign issue = accept & ~misalign;

    always_comb begin
        excp_valid_d = excp_valid_q;
        if (accept && misalign) begin
            excp_valid_d = 1'b1;
        end else if (agu_excp_ready) begin
            excp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            excp_valid_q <= 1'b0;
            excp_addr_q  <= '0;
            excp_itag_q  <= '0;
        end else begin
            excp_valid_q <= excp_valid_d;
            if (accept && misalign) begin
                excp_addr_q <= sum;
                excp_itag_q <= agu_i_itag;
            end
        end
    end

    assign excp_valid    = excp_valid_q;
    assign agu_excp_addr = excp_addr_q;
    assign agu_excp_itag = excp_itag_q;
`else
    logic unused_excp;

    assign issue         = accept;
    assign excp_valid    = 1'b0;
    assign agu_excp_addr = '0;
    assign agu_excp_itag = '0;
    assign unused_excp   = ^{misalign, sum[XLEN-1:DTCM_AW]};
`endif

    assign agu_excp_valid = excp_valid;

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        if (issue) begin
            cmd_valid_d = 1'b1;
        end else if (cmd_hs) begin
            cmd_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({cmd_hs, rsp_take})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_q <= 1'b0;
            cmd_read_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_wmask_q <= '0;
            cmd_itag_q  <= '0;
            cmd_usign_q <= 1'b0;
            cmd_size_q  <= '0;
            cnt_q       <= '0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cnt_q       <= cnt_d;
            if (issue) begin
                cmd_read_q  <= agu_i_read;
                cmd_addr_q  <= {sum[DTCM_AW-1:2], addr_lo};
                cmd_wdata_q <= lane_data;
                cmd_wmask_q <= agu_i_read ? '0 : lane_mask;
                cmd_itag_q  <= agu_i_itag;
                cmd_usign_q <= agu_i_usign;
                cmd_size_q  <= agu_i_size;
            end
        end
    end

    assign agu_cmd_valid = cmd_valid_q;
    assign agu_cmd_read  = cmd_read_q;
    assign agu_cmd_addr  = cmd_addr_q;
    assign agu_cmd_wdata = cmd_wdata_q;
    assign agu_cmd_wmask = cmd_wmask_q;
    assign agu_cmd_itag  = cmd_itag_q;
    assign agu_cmd_usign = cmd_usign_q;
    assign agu_cmd_size  = cmd_size_q;
    assign agu_rsp_ready = 1'b1;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(agu_rsp_valid && cnt_q == '0))
                else $warning("agu: agu_rsp_valid with no outstanding command, ignored");
        end
    end
`endif
endmodule

// File: tb/tb_agu.sv
// Directed bench for agu: address/lane forming, outstanding limit, counter corner cases,
// misaligned handling (both builds of AGU_MISALIGN_EXCP_EN) and asynchronous reset mid-stall.
module tb_agu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        agu_i_valid, agu_i_ready, agu_i_read, agu_i_usign;
    logic [31:0] agu_i_rs1, agu_i_rs2, agu_i_imm;
    logic [1:0]  agu_i_size;
    logic [3:0]  agu_i_itag;
    logic        agu_cmd_valid, agu_cmd_ready, agu_cmd_read, agu_cmd_usign;
    logic [15:0] agu_cmd_addr;
    logic [31:0] agu_cmd_wdata;
    logic [3:0]  agu_cmd_wmask, agu_cmd_itag;
    logic [1:0]  agu_cmd_size;
    logic        agu_rsp_valid, agu_rsp_ready;
    logic        agu_excp_valid, agu_excp_ready;
    logic [31:0] agu_excp_addr;
    logic [3:0]  agu_excp_itag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    agu #(.OUTS_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .agu_i_valid    (agu_i_valid),
        .agu_i_ready    (agu_i_ready),
        .agu_i_read     (agu_i_read),
        .agu_i_rs1      (agu_i_rs1),
        .agu_i_rs2      (agu_i_rs2),
        .agu_i_imm      (agu_i_imm),
        .agu_i_size     (agu_i_size),
        .agu_i_usign    (agu_i_usign),
        .agu_i_itag     (agu_i_itag),
        .agu_cmd_valid  (agu_cmd_valid),
        .agu_cmd_ready  (agu_cmd_ready),
        .agu_cmd_read   (agu_cmd_read),
        .agu_cmd_addr   (agu_cmd_addr),
        .agu_cmd_wdata  (agu_cmd_wdata),
        .agu_cmd_wmask  (agu_cmd_wmask),
        .agu_cmd_itag   (agu_cmd_itag),
        .agu_cmd_usign  (agu_cmd_usign),
        .agu_cmd_size   (agu_cmd_size),
        .agu_rsp_valid  (agu_rsp_valid),
        .agu_rsp_ready  (agu_rsp_ready),
        .agu_excp_valid (agu_excp_valid),
        .agu_excp_ready (agu_excp_ready),
        .agu_excp_addr  (agu_excp_addr),
        .agu_excp_itag  (agu_excp_itag)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rd, input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [31:0] rs2, input logic [1:0] sz, input logic us,
                          input logic [3:0] tag);
        agu_i_valid = 1'b1;
        agu_i_read  = rd;
        agu_i_rs1   = rs1;
        agu_i_imm   = imm;
        agu_i_rs2   = rs2;
        agu_i_size  = sz;
        agu_i_usign = us;
        agu_i_itag  = tag;
    endtask

    initial begin
        rst_n          = 1'b0;
        agu_i_valid    = 1'b0;
        agu_i_read     = 1'b0;
        agu_i_rs1      = '0;
        agu_i_rs2      = '0;
        agu_i_imm      = '0;
        agu_i_size     = '0;
        agu_i_usign    = 1'b0;
        agu_i_itag     = '0;
        agu_cmd_ready  = 1'b1;
        agu_rsp_valid  = 1'b0;
        agu_excp_ready = 1'b0;
        #12;
        check_eq("rst_cmd_valid", agu_cmd_valid, 0);
        check_eq("rst_excp_valid", agu_excp_valid, 0);
        check_eq("rst_cnt", dut.cnt_q, 0);
        check_eq("rst_cmd_addr", agu_cmd_addr, 0);
        check_eq("rst_rsp_ready", agu_rsp_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // lw 0x100+4
        set_op(1'b1, 32'h100, 32'h4, 32'h0, 2'b10, 1'b0, 4'h3);
        @(negedge clk);
        check_eq("lw_ready", agu_i_ready, 1);
        tick();
        agu_i_valid = 1'b0;
        check_eq("lw_valid", agu_cmd_valid, 1);
        check_eq("lw_addr", agu_cmd_addr, 16'h104);
        check_eq("lw_read", agu_cmd_read, 1);
        check_eq("lw_wmask", agu_cmd_wmask, 0);
        check_eq("lw_itag", agu_cmd_itag, 4'h3);
        check_eq("lw_cnt_before_hs", dut.cnt_q, 0);
        tick();
        check_eq("lw_cnt_after_hs", dut.cnt_q, 1);
        check_eq("lw_valid_drop", agu_cmd_valid, 0);
        agu_rsp_valid = 1'b1;
        tick();
        agu_rsp_valid = 1'b0;
        check_eq("lw_cnt_rsp", dut.cnt_q, 0);

        // sb @0x203 then sh @0x202 back-to-back
        set_op(1'b0, 32'h203, 32'h0, 32'hAB, 2'b00, 1'b0, 4'h1);
        tick();
        check_eq("sb_wmask", agu_cmd_wmask, 4'b1000);
        check_eq("sb_wdata", agu_cmd_wdata, 32'hABABABAB);
        check_eq("sb_addr", agu_cmd_addr, 16'h203);
        check_eq("sb_read", agu_cmd_read, 0);
        set_op(1'b0, 32'h200, 32'h2, 32'h1234, 2'b01, 1'b0, 4'h2);
        tick();
        agu_i_valid = 1'b0;
        check_eq("sh_wmask", agu_cmd_wmask, 4'b1100);
        check_eq("sh_wdata", agu_cmd_wdata, 32'h12341234);
        check_eq("sh_addr", agu_cmd_addr, 16'h202);
        check_eq("sh_size", agu_cmd_size, 2'b01);
        check_eq("sb_cnt", dut.cnt_q, 1);
        tick();
        check_eq("sh_cnt", dut.cnt_q, 2);
        agu_rsp_valid = 1'b1;
        tick();
        tick();
        agu_rsp_valid = 1'b0;
        check_eq("drain_cnt", dut.cnt_q, 0);

        // sw with negative imm and address above the DTCM window; then lbu
        set_op(1'b0, 32'h0001_2008, 32'hFFFF_FFF8, 32'hDEADBEEF, 2'b10, 1'b0, 4'h7);
        tick();
        agu_i_valid = 1'b0;
        check_eq("sw_addr_trunc", agu_cmd_addr, 16'h2000);
        check_eq("sw_wmask", agu_cmd_wmask, 4'b1111);
        check_eq("sw_wdata", agu_cmd_wdata, 32'hDEADBEEF);
        tick();
        set_op(1'b1, 32'h41, 32'h0, 32'h0, 2'b00, 1'b1, 4'h9);
        tick();
        agu_i_valid = 1'b0;
        check_eq("lbu_usign", agu_cmd_usign, 1);
        check_eq("lbu_wmask", agu_cmd_wmask, 0);
        check_eq("lbu_addr", agu_cmd_addr, 16'h41);
        check_eq("lbu_itag", agu_cmd_itag, 4'h9);
        tick();
        agu_rsp_valid = 1'b1;
        tick();
        tick();
        agu_rsp_valid = 1'b0;
        check_eq("drain2_cnt", dut.cnt_q, 0);

        // Outstanding limit: three back-to-back ops, no responses
        set_op(1'b1, 32'h400, 32'h0, 32'h0, 2'b10, 1'b0, 4'hA);
        @(negedge clk);
        check_eq("lim_ready_a", agu_i_ready, 1);
        tick();
        set_op(1'b1, 32'h404, 32'h0, 32'h0, 2'b10, 1'b0, 4'hB);
        @(negedge clk);
        check_eq("lim_ready_b", agu_i_ready, 1);
        tick();
        set_op(1'b1, 32'h408, 32'h0, 32'h0, 2'b10, 1'b0, 4'hC);
        @(negedge clk);
        check_eq("lim_ready_c_blocked", agu_i_ready, 0);
        tick();
        check_eq("lim_cnt_full", dut.cnt_q, 2);
        check_eq("lim_cmd_idle", agu_cmd_valid, 0);
        @(negedge clk);
        check_eq("lim_ready_full", agu_i_ready, 0);
        agu_rsp_valid = 1'b1;
        tick();
        agu_rsp_valid = 1'b0;
        @(negedge clk);
        check_eq("lim_ready_after_rsp", agu_i_ready, 1);
        tick();
        agu_i_valid = 1'b0;
        check_eq("lim_c_valid", agu_cmd_valid, 1);
        check_eq("lim_c_addr", agu_cmd_addr, 16'h408);
        check_eq("lim_c_itag", agu_cmd_itag, 4'hC);
        tick();
        check_eq("lim_cnt_c", dut.cnt_q, 2);

        // Handshake coinciding with response, then response at zero
        agu_rsp_valid = 1'b1;
        tick();
        agu_rsp_valid = 1'b0;
        check_eq("coin_cnt_pre", dut.cnt_q, 1);
        set_op(1'b1, 32'h500, 32'h0, 32'h0, 2'b10, 1'b0, 4'hD);
        tick();
        agu_i_valid   = 1'b0;
        agu_rsp_valid = 1'b1;
        tick();
        check_eq("coin_cnt_same", dut.cnt_q, 1);
        tick();
        check_eq("coin_cnt_drain", dut.cnt_q, 0);
        tick();
        agu_rsp_valid = 1'b0;
        check_eq("rsp_at_zero_cnt", dut.cnt_q, 0);
        @(negedge clk);
        check_eq("rsp_at_zero_ready", agu_i_ready, 1);

        // Misaligned lw @0x102
        tick();
        set_op(1'b1, 32'h100, 32'h2, 32'h0, 2'b10, 1'b0, 4'h2);
        tick();
        agu_i_valid = 1'b0;
`ifdef AGU_MISALIGN_EXCP_EN
        check_eq("mis_excp_valid", agu_excp_valid, 1);
        check_eq("mis_excp_addr", agu_excp_addr, 32'h102);
        check_eq("mis_excp_itag", agu_excp_itag, 4'h2);
        check_eq("mis_no_cmd", agu_cmd_valid, 0);
        @(negedge clk);
        check_eq("mis_ready_blocked", agu_i_ready, 0);
        agu_excp_ready = 1'b1;
        @(negedge clk);
        check_eq("mis_ready_excp_rdy", agu_i_ready, 1);
        tick();
        agu_excp_ready = 1'b0;
        check_eq("mis_excp_clear", agu_excp_valid, 0);
        check_eq("mis_cnt", dut.cnt_q, 0);
`else
        check_eq("mis_cmd_valid", agu_cmd_valid, 1);
        check_eq("mis_cmd_addr", agu_cmd_addr, 16'h100);
        check_eq("mis_excp_valid", agu_excp_valid, 0);
        tick();
        set_op(1'b0, 32'h203, 32'h0, 32'h5566, 2'b01, 1'b0, 4'h4);
        tick();
        agu_i_valid = 1'b0;
        check_eq("mis_sh_addr", agu_cmd_addr, 16'h202);
        check_eq("mis_sh_wmask", agu_cmd_wmask, 4'b1100);
        check_eq("mis_sh_wdata", agu_cmd_wdata, 32'h55665566);
        tick();
        agu_rsp_valid = 1'b1;
        tick();
        tick();
        agu_rsp_valid = 1'b0;
        check_eq("mis_drain_cnt", dut.cnt_q, 0);
`endif

        // LSU stall for 3 cycles, then asynchronous reset mid-stall
        agu_cmd_ready = 1'b0;
        set_op(1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 2'b10, 1'b0, 4'h5);
        tick();
        set_op(1'b1, 32'h600, 32'h0, 32'h0, 2'b10, 1'b0, 4'h6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_ready", agu_i_ready, 0);
            check_eq("stall_valid", agu_cmd_valid, 1);
            check_eq("stall_addr", agu_cmd_addr, 16'h300);
            check_eq("stall_wdata", agu_cmd_wdata, 32'hCAFEF00D);
            check_eq("stall_itag", agu_cmd_itag, 4'h5);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_cmd_valid", agu_cmd_valid, 0);
        check_eq("arst_cnt", dut.cnt_q, 0);
        check_eq("arst_excp_valid", agu_excp_valid, 0);
        check_eq("arst_cmd_addr", agu_cmd_addr, 0);
        agu_i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
